// File: rtl/uart_conv8to16.sv
// uart_conv8to16: pairs UART bytes (high first) into 16-bit words.
// Optional build macro UART_CONV_TAG_CHECK_EN: reject bad high-byte tags.
module uart_conv8to16 #(
  parameter int TIMEOUT_CYCLES = 250000,
  parameter int CNT_W          = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_done,
  output logic [15:0] data,
  output logic        conv8to16valid,
  output logic        timeout_err,
  output logic [15:0] word_cnt
);

  typedef enum logic {
    WAIT_HI,
    WAIT_LO
  } state_t;

  localparam logic [CNT_W-1:0] TERM =
    (TIMEOUT_CYCLES == 0) ? '0 : CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

  state_t           state;
  logic [7:0]       hi_reg;
  logic [CNT_W-1:0] timer;
  logic             tag_ok;

`ifdef UART_CONV_TAG_CHECK_EN
  // High bytes carry a tag nibble; anything else means we are misaligned.
  assign tag_ok = rx_data[7:4] inside {4'h0, 4'h3, 4'h4, 4'h5, 4'h6};
`else
  assign tag_ok = 1'b1;
`endif

  // Byte pairing FSM with inter-byte timeout; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= WAIT_HI;
      hi_reg         <= 8'h00;
      timer          <= '0;
      data           <= 16'h0000;
      conv8to16valid <= 1'b0;
      timeout_err    <= 1'b0;
      word_cnt       <= 16'h0000;
    end else begin
      conv8to16valid <= 1'b0;
      timeout_err    <= 1'b0;
      unique case (state)
        WAIT_HI: begin
          if (rx_done && tag_ok) begin
            hi_reg <= rx_data;
            timer  <= '0;
            state  <= WAIT_LO;
          end else if (rx_done) begin
            timeout_err <= 1'b1;
          end
        end
        WAIT_LO: begin
          if (rx_done) begin
            data           <= {hi_reg, rx_data};
            conv8to16valid <= 1'b1;
            word_cnt       <= word_cnt + 16'd1;
            state          <= WAIT_HI;
          end else if (TO_EN) begin
            if (timer == TERM) begin
              timeout_err <= 1'b1;
              state       <= WAIT_HI;
            end else begin
              timer <= timer + 1'b1;
            end
          end else begin
            timer <= '0;
          end
        end
        default: state <= WAIT_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_conv8to16.sv
// tb_uart_conv8to16: directed vectors for the byte-to-word assembler.
// Runs with TIMEOUT_CYCLES=20 so the timeout paths are reachable.
module tb_uart_conv8to16;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_done = 1'b0;
  logic [15:0] data;
  logic        conv8to16valid;
  logic        timeout_err;
  logic [15:0] word_cnt;

  int checks = 0;
  int failures = 0;
  int exp_cnt = 0;
  int err_seen;
  int val_seen;

  uart_conv8to16 #(
    .TIMEOUT_CYCLES(TO),
    .CNT_W(18)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_data(rx_data),
    .rx_done(rx_done),
    .data(data),
    .conv8to16valid(conv8to16valid),
    .timeout_err(timeout_err),
    .word_cnt(word_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Present one byte; returns #1 after the sampling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) tick();
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("rst_data", {16'h0, data}, 32'h0);
    check("rst_valid", {31'h0, conv8to16valid}, 32'h0);
    check("rst_err", {31'h0, timeout_err}, 32'h0);
    check("rst_cnt", {16'h0, word_cnt}, 32'h0);

    // Basic pair, bytes ten cycles apart
    send(8'h31);
    repeat (9) tick();
    send(8'h23);
    exp_cnt++;
    check("w1_valid", {31'h0, conv8to16valid}, 32'h1);
    check("w1_data", {16'h0, data}, 32'h3123);
    check("w1_cnt", {16'h0, word_cnt}, exp_cnt);
    tick();
    check("w1_valid_off", {31'h0, conv8to16valid}, 32'h0);
    check("w1_hold", {16'h0, data}, 32'h3123);

    // Back-to-back bytes
    send(8'h5A);
    check("b2b_v0", {31'h0, conv8to16valid}, 32'h0);
    send(8'hBC);
    exp_cnt++;
    check("b2b_v1", {31'h0, conv8to16valid}, 32'h1);
    check("b2b_d1", {16'h0, data}, 32'h5ABC);
    send(8'h60);
    check("b2b_v2", {31'h0, conv8to16valid}, 32'h0);
    send(8'h01);
    exp_cnt++;
    check("b2b_v3", {31'h0, conv8to16valid}, 32'h1);
    check("b2b_d3", {16'h0, data}, 32'h6001);
    check("b2b_cnt", {16'h0, word_cnt}, exp_cnt);

    // Timeout on a lone high byte
    send(8'h40);
    err_seen = 0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (timeout_err) err_seen++;
    end
    check("to_early", err_seen, 0);
    tick();
    check("to_pulse", {31'h0, timeout_err}, 32'h1);
    check("to_novalid", {31'h0, conv8to16valid}, 32'h0);
    tick();
    check("to_once", {31'h0, timeout_err}, 32'h0);
    send(8'h41);
    send(8'h02);
    exp_cnt++;
    check("to_next_v", {31'h0, conv8to16valid}, 32'h1);
    check("to_next_d", {16'h0, data}, 32'h4102);
    check("to_cnt", {16'h0, word_cnt}, exp_cnt);

    // Low byte on the terminal-count cycle
    send(8'h50);
    repeat (TO - 1) tick();
    send(8'h77);
    exp_cnt++;
    check("tie_v", {31'h0, conv8to16valid}, 32'h1);
    check("tie_d", {16'h0, data}, 32'h5077);
    check("tie_err", {31'h0, timeout_err}, 32'h0);
    tick();
    check("tie_err2", {31'h0, timeout_err}, 32'h0);

    // Reset while a high byte is pending
    send(8'h3F);
    @(negedge clk);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    check("mid_rst_cnt", {16'h0, word_cnt}, 32'h0);
    check("mid_rst_data", {16'h0, data}, 32'h0);
    send(8'h04);
    check("mid_rst_v0", {31'h0, conv8to16valid}, 32'h0);
    send(8'h10);
    exp_cnt++;
    check("mid_rst_v", {31'h0, conv8to16valid}, 32'h1);
    check("mid_rst_d", {16'h0, data}, 32'h0410);
    check("mid_rst_cnt1", {16'h0, word_cnt}, exp_cnt);

    // Tag check behaviour
    tick();
    send(8'hA5);
`ifdef UART_CONV_TAG_CHECK_EN
    check("tag_err", {31'h0, timeout_err}, 32'h1);
    check("tag_v0", {31'h0, conv8to16valid}, 32'h0);
    send(8'h30);
    check("tag_err_off", {31'h0, timeout_err}, 32'h0);
    send(8'h11);
    exp_cnt++;
    check("tag_v", {31'h0, conv8to16valid}, 32'h1);
    check("tag_d", {16'h0, data}, 32'h3011);
    check("tag_cnt", {16'h0, word_cnt}, exp_cnt);
`else
    check("notag_err", {31'h0, timeout_err}, 32'h0);
    send(8'h30);
    exp_cnt++;
    check("notag_v", {31'h0, conv8to16valid}, 32'h1);
    check("notag_d", {16'h0, data}, 32'hA530);
    send(8'h11);
    val_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (conv8to16valid) val_seen++;
    end
    check("notag_pend", val_seen, 0);
    send(8'h22);
    exp_cnt++;
    check("notag_v2", {31'h0, conv8to16valid}, 32'h1);
    check("notag_d2", {16'h0, data}, 32'h1122);
    check("notag_cnt", {16'h0, word_cnt}, exp_cnt);
`endif

    repeat (2) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
